// File: rtl/key_search_ctrl.sv
// Result controller for the parallel RC4 key search: launches all cores, arbitrates the first found key, reports success or exhaustion.
// Defining SEARCH_CYCLE_COUNT_EN adds the saturating search_cycles output.
module key_search_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24,
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES-1:0]       core_exhausted,
  output logic [NUM_CORES-1:0]       core_start,
  output logic                       core_stop,
  output logic                       busy,
  output logic                       done,
  output logic                       success,
  output logic [KEY_W-1:0]           secret_key,
  output logic [IDX_W-1:0]           winner_idx
`ifdef SEARCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]                search_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_OK,
    DONE_FAIL
  } state_t;

  state_t                 state;
  logic [NUM_CORES-1:0]   sticky;
  logic [NUM_CORES-1:0]   sticky_next;
  logic                   found_any;
  logic                   all_exhausted;
  logic [IDX_W-1:0]       win_idx;
  logic [KEY_W-1:0]       win_key;

  // Scan from the top down so the lowest-index found core is the last assignment and wins.
  always_comb begin
    win_idx = '0;
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        win_idx = IDX_W'(i);
        win_key = core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  assign found_any     = |core_found;
  assign sticky_next   = sticky | core_exhausted;
  assign all_exhausted = &sticky_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sticky     <= '0;
      core_start <= '0;
      core_stop  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      success    <= 1'b0;
      secret_key <= '0;
      winner_idx <= '0;
    end else begin
      core_start <= '0;
      case (state)
        IDLE, DONE_OK, DONE_FAIL: begin
          if (start) begin
            state      <= RUN;
            sticky     <= '0;
            core_start <= '1;
            core_stop  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            success    <= 1'b0;
            secret_key <= '0;
            winner_idx <= '0;
          end
        end
        RUN: begin
          // A found in the same cycle as the final exhaustion still counts as success.
          if (found_any) begin
            state      <= DONE_OK;
            core_stop  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            success    <= 1'b1;
            secret_key <= win_key;
            winner_idx <= win_idx;
          end else begin
            sticky <= sticky_next;
            if (all_exhausted) begin
              state     <= DONE_FAIL;
              core_stop <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEARCH_CYCLE_COUNT_EN
  // Counts every RUN cycle including the one that ends the search; frozen once done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      search_cycles <= '0;
    end else if (state == RUN) begin
      if (search_cycles != 32'hFFFF_FFFF) begin
        search_cycles <= search_cycles + 32'd1;
      end
    end else if (start) begin
      search_cycles <= '0;
    end
  end
`endif

endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Parametrised result controller for the parallel RC4 key-search datapath. It launches NUM_CORES decryption cores together and watches their found and exhausted flags. It latches the key from the first core to report a successful decryption, stops every core, and reports either success or failure (whole keyspace exhausted). It sits between the decryption cores and the top-level display/LED logic and replaces the fixed four-core combinational key selector with a sequential, arbitrated block.

## Interface
Parameters:
- NUM_CORES, 4: number of decryption cores, legal range 1..16
- KEY_W, 24: key width in bits
- IDX_W, derived: max($clog2(NUM_CORES),1), width of winner index

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a search; sampled only in IDLE, DONE_OK or DONE_FAIL
- core_key  in  NUM_CORES*KEY_W  current key of each core; core i occupies bits [i*KEY_W +: KEY_W]
- core_found  in  NUM_CORES  core i decrypted a valid message with its current key (level or pulse)
- core_exhausted  in  NUM_CORES  core i finished its key sub-range with no match (level or pulse)
- core_start  out  NUM_CORES  one-cycle launch pulse to every core
- core_stop  out  1  halt all cores; held high in DONE_OK and DONE_FAIL
- busy  out  1  search in progress (state RUN)
- done  out  1  search finished (DONE_OK or DONE_FAIL)
- success  out  1  done with a key found
- secret_key  out  KEY_W  winning key; 0 unless success
- winner_idx  out  IDX_W  index of the winning core; 0 unless success

## Operation
- States: IDLE, RUN, DONE_OK, DONE_FAIL. All outputs are registered.
- IDLE: when start=1, go to RUN and pulse core_start to all ones for one cycle. Clear the sticky exhausted vector.
- RUN: core_found and core_exhausted are evaluated every cycle.
  - If any core_found bit is set: the lowest-index set bit wins. Latch its core_key slice into secret_key and its index into winner_idx, then go to DONE_OK.
  - Otherwise, OR core_exhausted into a sticky vector. When the sticky vector (including this cycle's bits) is all ones, go to DONE_FAIL.
  - Found has priority over exhausted in the same cycle, including the cycle that would complete exhaustion.
  - start is ignored in RUN.
- DONE_OK / DONE_FAIL: done=1 and core_stop=1. Outputs hold until start=1. start clears secret_key, winner_idx, success and the sticky vector, then re-enters RUN with a fresh core_start pulse.
- core_found and core_exhausted are ignored outside RUN.
- Reset mid-search: the block returns to IDLE immediately. core_start and core_stop drop to 0, so cores are neither stopped nor relaunched until the next start.

## Timing
- Reset values: state IDLE; core_start=0, core_stop=0, busy=0, done=0, success=0, secret_key=0, winner_idx=0; sticky vector 0.
- start sampled high at edge t (in IDLE or a DONE state): from t+1, busy=1, done=0, and core_start is all ones for exactly one cycle.
- Found or exhaustion condition sampled at edge t in RUN: from t+1, busy=0, done=1, core_stop=1. success, secret_key and winner_idx are valid in the same cycle as done.
- The earliest found that is acted upon is in the first RUN cycle, i.e. the cycle core_start is high.
- Throughput: one search at a time. The minimum start-to-done latency is 2 cycles.

## Configuration
- SEARCH_CYCLE_COUNT_EN
  - Defined: adds output search_cycles [31:0], reset 0.
    - Cleared on an accepted start.
    - Increments every cycle in RUN, including the final RUN cycle.
    - Saturates at 32'hFFFF_FFFF.
    - Frozen in DONE states.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then start; core_found=4'b0100 with core_key slice 2=24'h00_0249 on the third RUN cycle -> next cycle done=1, success=1, secret_key=24'h000249, winner_idx=2, core_stop=1; search_cycles=3 when enabled.
- Simultaneous found 4'b1010 with keys k1=24'h1, k3=24'h3 -> secret_key=24'h1, winner_idx=1.
- Exhausted pulses arrive individually on cores 0, 2, 1, 3 in separate cycles -> done=1, success=0, secret_key=0 the cycle after core 3's pulse.
- The cycle completing exhaustion also has core_found[0]=1 -> DONE_OK with winner_idx=0.
- In DONE_OK, assert start -> secret_key=0, done=0, busy=1, core_start all ones for one cycle; in RUN, a second start pulse has no effect.
- rst_n low for one cycle in mid-RUN -> all outputs reset immediately; core_found asserted afterwards with no start leaves done=0.
